// File: rtl/rm13_pkg.sv
// Shared RM(1,3) / extended Hamming (8,4) constants and the nibble encoder,
// used by both the encoder stream and the decoder side.
package rm13_pkg;

    localparam int LANE_W   = 8;
    localparam int NIBBLE_W = 4;

    localparam logic [LANE_W-1:0] G0 = 8'h0F;
    localparam logic [LANE_W-1:0] G1 = 8'h33;
    localparam logic [LANE_W-1:0] G2 = 8'h55;
    localparam logic [LANE_W-1:0] G3 = 8'hFF;

    function automatic logic [LANE_W-1:0] rm13_encode_nibble(input logic [NIBBLE_W-1:0] d);
        return ({LANE_W{d[0]}} & G0) ^ ({LANE_W{d[1]}} & G1) ^
               ({LANE_W{d[2]}} & G2) ^ ({LANE_W{d[3]}} & G3);
    endfunction

endpackage

// File: rtl/rm13_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter so full/empty never alias;
// the read port is the registered head entry (no write-through bypass).
module rm13_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]            level_q;
    logic                        do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/rm13_encoder_stream.sv
// Streaming RM(1,3) encoder: one 8-bit codeword lane per input nibble, buffered
// in an elastic FIFO. Define RM13_ENCODER_ERR_INJECT_EN for bit-error injection.
module rm13_encoder_stream
    import rm13_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clear,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DATA_WIDTH/2-1:0]            s_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
`ifdef RM13_ENCODER_ERR_INJECT_EN
    input  logic                               inj_en,
    input  logic [DATA_WIDTH/8-1:0]            inj_lane_mask,
    input  logic [2:0]                         inj_bit,
    output logic [COUNT_WIDTH-1:0]             inj_count,
`endif
    output logic [COUNT_WIDTH-1:0]             words_encoded
);

    localparam int LANES = DATA_WIDTH / LANE_W;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                   alive_q;
    logic                   full, empty, push;
    logic [DATA_WIDTH-1:0]  cw;
    logic [COUNT_WIDTH-1:0] words_q;

    // alive_q keeps s_ready low until the first edge after reset release.
    assign s_ready = alive_q & ~full & ~clear;
    assign push    = s_valid & s_ready;
    assign m_valid = ~empty;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef RM13_ENCODER_ERR_INJECT_EN
        logic [LANE_W-1:0] flip;
        assign flip = {{(LANE_W-1){1'b0}}, inj_en & inj_lane_mask[i]} << inj_bit;
        assign cw[LANE_W*i +: LANE_W] = rm13_encode_nibble(s_data[NIBBLE_W*i +: NIBBLE_W]) ^ flip;
`else
        assign cw[LANE_W*i +: LANE_W] = rm13_encode_nibble(s_data[NIBBLE_W*i +: NIBBLE_W]);
`endif
    end

    rm13_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .pop     (m_ready),
        .wdata   (cw),
        .rdata   (m_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive_q <= 1'b0;
            words_q <= '0;
        end else begin
            alive_q <= 1'b1;
            if (clear)     words_q <= '0;
            else if (push) words_q <= words_q + COUNT_WIDTH'(1);
        end
    end

    assign words_encoded = words_q;

`ifdef RM13_ENCODER_ERR_INJECT_EN
    logic [COUNT_WIDTH-1:0] inj_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         inj_q <= '0;
        else if (clear)                       inj_q <= '0;
        else if (push & inj_en & |inj_lane_mask) inj_q <= inj_q + COUNT_WIDTH'(1);
    end

    assign inj_count = inj_q;
`endif

endmodule

// File: tb/tb_rm13_encoder_stream.sv
// Randomised + directed bench for rm13_encoder_stream against a queue-based model
// that evaluates each codeword as an affine Boolean function over bit positions.
module tb_rm13_encoder_stream;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [15:0]   s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;
    logic [2:0]    fifo_level;
    logic [15:0]   words_encoded;
`ifdef RM13_ENCODER_ERR_INJECT_EN
    logic          inj_en = 1'b0;
    logic [3:0]    inj_lane_mask = '0;
    logic [2:0]    inj_bit = '0;
    logic [15:0]   inj_count;
    int            m_inj = 0;
`endif

    always #5 clk = ~clk;

    rm13_encoder_stream #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .fifo_level    (fifo_level),
`ifdef RM13_ENCODER_ERR_INJECT_EN
        .inj_en        (inj_en),
        .inj_lane_mask (inj_lane_mask),
        .inj_bit       (inj_bit),
        .inj_count     (inj_count),
`endif
        .words_encoded (words_encoded)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   mq[$];
    int            m_cnt   = 0;
    bit            m_alive = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Codeword bit j of an RM(1,3) word is the affine function
    // d3 ^ d0*!j2 ^ d1*!j1 ^ d2*!j0 evaluated at position j.
    function automatic logic [31:0] model_word(input logic [15:0] sd);
        logic [31:0] w;
        logic [3:0]  d;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            d = sd[4*l +: 4];
            for (int j = 0; j < 8; j++)
                w[8*l+j] = d[3] ^ (d[0] & ~j[2]) ^ (d[1] & ~j[1]) ^ (d[2] & ~j[0]);
`ifdef RM13_ENCODER_ERR_INJECT_EN
            if (inj_en && inj_lane_mask[l]) w[8*l + int'(inj_bit)] = ~w[8*l + int'(inj_bit)];
`endif
        end
        return w;
    endfunction

    task automatic compare();
        chk("s_ready", {31'd0, s_ready}, {31'd0, m_alive && mq.size() < DEPTH && !clear});
        chk("m_valid", {31'd0, m_valid}, {31'd0, mq.size() != 0});
        chk("fifo_level", {29'd0, fifo_level}, 32'(mq.size()));
        chk("words_encoded", {16'd0, words_encoded}, 32'(m_cnt & 16'hFFFF));
        if (mq.size() != 0) chk("m_data", m_data, mq[0]);
`ifdef RM13_ENCODER_ERR_INJECT_EN
        chk("inj_count", {16'd0, inj_count}, 32'(m_inj & 16'hFFFF));
`endif
    endtask

    // Called at a negedge: drive inputs, advance the model across the posedge, compare.
    task automatic step(input logic sv, input logic [15:0] sd, input logic mr, input logic clr,
                        output logic acc, output logic popd, output logic [31:0] pw);
        logic [31:0] enc;
        s_valid = sv; s_data = sd; m_ready = mr; clear = clr;
        acc  = sv && m_alive && mq.size() < DEPTH && !clr;
        popd = mq.size() != 0 && mr && !clr;
        pw   = popd ? mq[0] : 32'd0;
        enc  = model_word(sd);
        @(posedge clk);
        if (clr) begin
            mq.delete();
            m_cnt = 0;
`ifdef RM13_ENCODER_ERR_INJECT_EN
            m_inj = 0;
`endif
        end else begin
            if (popd) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(enc);
                m_cnt++;
`ifdef RM13_ENCODER_ERR_INJECT_EN
                if (inj_en && inj_lane_mask != 0) m_inj++;
`endif
            end
        end
        m_alive = 1;
        @(negedge clk);
        compare();
    endtask

    task automatic reset_model();
        mq.delete();
        m_cnt = 0;
        m_alive = 0;
`ifdef RM13_ENCODER_ERR_INJECT_EN
        m_inj = 0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc, popd;
        logic [31:0] pw;
        logic [15:0] w3 [5];
        logic [31:0] dq[$];
        int          k, pushes, pops;
        logic [15:0] t2 [4];
        logic [31:0] e2 [4];

        // Pin the model to hand-computed reference codewords.
        chk("model 0", model_word(16'h0000), 32'h00000000);
        chk("model 1", model_word(16'h0001), 32'h0000000F);
        chk("model 2", model_word(16'h0002), 32'h00000033);
        chk("model 3", model_word(16'h0003), 32'h0000003C);
        chk("model 4", model_word(16'h0004), 32'h00000055);
        chk("model 8", model_word(16'h0008), 32'h000000FF);
        chk("model 8421", model_word(16'h8421), 32'hFF55330F);

        repeat (3) @(negedge clk);
        chk("rst s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst m_data", m_data, 32'd0);
        chk("rst level", {29'd0, fifo_level}, 32'd0);
        chk("rst count", {16'd0, words_encoded}, 32'd0);
        reset_n = 1'b1;
        step(0, 16'h0, 1, 0, acc, popd, pw);
        chk("ready after release", {31'd0, s_ready}, 32'd1);

        // Single word latency.
        step(1, 16'h0001, 1, 0, acc, popd, pw);
        chk("t1 m_valid", {31'd0, m_valid}, 32'd1);
        chk("t1 m_data", m_data, 32'h0000000F);
        chk("t1 count", {16'd0, words_encoded}, 32'd1);

        // Back-to-back stream.
        t2[0] = 16'h0002; t2[1] = 16'h0003; t2[2] = 16'h0004; t2[3] = 16'h8421;
        e2[0] = 32'h00000033; e2[1] = 32'h0000003C; e2[2] = 32'h00000055; e2[3] = 32'hFF55330F;
        for (int i = 0; i < 4; i++) begin
            step(1, t2[i], 1, 0, acc, popd, pw);
            chk("t2 m_data", m_data, e2[i]);
        end
        step(0, 16'h0, 1, 0, acc, popd, pw);
        chk("t2 drained", {31'd0, m_valid}, 32'd0);

        // Fill to full with the sink stalled; fifth word held at the source.
        w3[0] = 16'h1111; w3[1] = 16'h2222; w3[2] = 16'h3456; w3[3] = 16'h789A; w3[4] = 16'hBCDE;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, w3[k], 0, 0, acc, popd, pw);
            if (acc) k++;
        end
        chk("t3 accepted", 32'(k), 32'd4);
        chk("t3 level", {29'd0, fifo_level}, 32'd4);
        chk("t3 s_ready full", {31'd0, s_ready}, 32'd0);
        for (int i = 0; i < 30 && (dq.size() < 5); i++) begin
            step(k < 5, (k < 5) ? w3[k] : 16'h0, 1, 0, acc, popd, pw);
            if (i == 0) chk("t3 no push while full", {31'd0, acc}, 32'd0);
            if (acc) k++;
            if (popd) dq.push_back(pw);
        end
        chk("t3 delivered", 32'(dq.size()), 32'd5);
        for (int i = 0; i < 5 && i < dq.size(); i++) chk("t3 order", dq[i], model_word(w3[i]));

        // Steady state at level 2 with simultaneous push and pop.
        step(1, 16'hA5A5, 0, 0, acc, popd, pw);
        step(1, 16'h5A5A, 0, 0, acc, popd, pw);
        chk("t4 level start", {29'd0, fifo_level}, 32'd2);
        pushes = 0; pops = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 16'($urandom), 1, 0, acc, popd, pw);
            pushes += int'(acc); pops += int'(popd);
            chk("t4 level", {29'd0, fifo_level}, 32'd2);
        end
        chk("t4 pushes", 32'(pushes), 32'd10);
        chk("t4 pops", 32'(pops), 32'd10);

        // Clear at level 3 with a word offered.
        step(1, 16'h0F0F, 0, 0, acc, popd, pw);
        chk("t5 level 3", {29'd0, fifo_level}, 32'd3);
        step(1, 16'hF0F0, 1, 1, acc, popd, pw);
        chk("t5 level", {29'd0, fifo_level}, 32'd0);
        chk("t5 m_valid", {31'd0, m_valid}, 32'd0);
        chk("t5 count", {16'd0, words_encoded}, 32'd0);
        step(0, 16'h0, 1, 0, acc, popd, pw);
        chk("t5 still empty", {31'd0, m_valid}, 32'd0);

`ifdef RM13_ENCODER_ERR_INJECT_EN
        inj_en = 1'b1; inj_lane_mask = 4'b0001;
        inj_bit = 3'd3; step(1, 16'h0001, 1, 0, acc, popd, pw); chk("t6 d1", m_data, 32'h00000007);
        inj_bit = 3'd7; step(1, 16'h0002, 1, 0, acc, popd, pw); chk("t6 d2", m_data, 32'h000000B3);
        inj_bit = 3'd6; step(1, 16'h0003, 1, 0, acc, popd, pw); chk("t6 d3", m_data, 32'h0000007C);
        inj_bit = 3'd5; step(1, 16'h0004, 1, 0, acc, popd, pw); chk("t6 d4", m_data, 32'h00000075);
        chk("t6 inj_count", {16'd0, inj_count}, 32'd4);
        inj_en = 1'b0;
        step(0, 16'h0, 1, 0, acc, popd, pw);
`endif

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
`ifdef RM13_ENCODER_ERR_INJECT_EN
            inj_en = ($urandom_range(0, 3) == 0);
            inj_lane_mask = 4'($urandom);
            inj_bit = 3'($urandom);
`endif
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0, acc, popd, pw);
        end

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 0, acc, popd, pw);
        reset_n = 1'b0;
        #1;
        reset_model();
        chk("async rst level", {29'd0, fifo_level}, 32'd0);
        chk("async rst m_valid", {31'd0, m_valid}, 32'd0);
        chk("async rst m_data", m_data, 32'd0);
        chk("async rst count", {16'd0, words_encoded}, 32'd0);
        chk("async rst s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1, 0, acc, popd, pw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rm13_encoder_stream.md
Name: rm13_encoder_stream

Overview:
- Streaming RM(1,3) / extended Hamming (8,4) encoder; directly upstream of decoder_top.
- Produces the codeword words that are written into the decoder input register (address 2). Decoder output register (address 3) must return the original nibbles.
- Each 4-bit data nibble maps to one 8-bit codeword lane. Output goes through a small elastic FIFO with valid/ready on both sides.

Parameters:
- DATA_WIDTH, 32, codeword word width; must be a multiple of 8; LANES = DATA_WIDTH/8.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- COUNT_WIDTH, 16, width of encoded-word counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of FIFO and counter.
- s_valid  in  1  input nibble-word valid.
- s_ready  out  1  input accept; high when FIFO not full and clear low.
- s_data  in  DATA_WIDTH/2  LANES nibbles; nibble i = s_data[4i+3:4i].
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  head codeword; lane i = m_data[8i+7:8i].
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- words_encoded  out  COUNT_WIDTH  count of accepted words; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async, reset_n low): s_ready=0 during reset, 1 on the first cycle after release. m_valid=0, m_data=0, fifo_level=0, words_encoded=0, FIFO pointers=0.
- Encode function, per lane: cw = (d0?0x0F:0) ^ (d1?0x33:0) ^ (d2?0x55:0) ^ (d3?0xFF:0).
  - Reference values: 0→0x00, 1→0x0F, 2→0x33, 3→0x3C, 4→0x55, 8→0xFF.
- Encoding is combinational on s_data. The result is written into the FIFO at the accepting edge (s_valid & s_ready).
- Latency: a word accepted at edge N is visible on m_data with m_valid=1 after edge N when the FIFO was empty. No bypass path; m_data is always the registered FIFO head.
- Pop: occurs on m_valid & m_ready.
- s_ready depends only on registered state: !full & !clear. No combinational path from m_ready.
- Full: s_ready=0 even if a pop occurs in the same cycle. The pushed word is not lost; the source holds it.
- Empty: m_valid=0; m_data holds its last value, and its value is don't-care.
- Simultaneous push and pop when 0<level<FIFO_DEPTH: level unchanged, pointers both advance, order preserved.
- Pointers wrap modulo FIFO_DEPTH. Level is tracked separately so that full and empty are unambiguous.
- clear=1 at an edge:
  - level←0, pointers←0, words_encoded←0.
  - Any push in that cycle is blocked (s_ready=0); any pop in that cycle is discarded.
- words_encoded increments on each accepted push.
- Reset asserted mid-stream: all state is discarded immediately (async). There is no partial-word recovery.

Optional Feature:
- Macro: RM13_ENCODER_ERR_INJECT_EN.
- Defined:
  - Adds ports inj_en (in, 1), inj_lane_mask (in, LANES), inj_bit (in, 3), and inj_count (out, COUNT_WIDTH, reset 0, cleared by clear).
  - On an accepted push with inj_en=1, each lane with its mask bit set has codeword bit inj_bit inverted before the FIFO write.
  - inj_count increments by 1 per accepted push with inj_en=1 and mask≠0.
  - Purpose: generating single-bit-error vectors for decoder correction tests.
- Undefined: those ports do not exist and codewords are never altered.

Decomposition:
- Package rm13_pkg holds:
  - constants G0=8'h0F, G1=8'h33, G2=8'h55, G3=8'hFF, LANE_W=8, NIBBLE_W=4;
  - function rm13_encode_nibble(4b)→8b.
- The decoder side reuses the same package for syndrome/majority logic.
- One sub-module: rm13_sync_fifo, parameterised by width and depth. It provides push, pop, full, empty, level and clear. The top instantiates it alongside the lane-encoder generate loop and the counter.

Test Plan:
1. Reset then s_data=16'h0001, m_ready=1 → m_data=32'h0000000F one cycle later; words_encoded=1.
2. Sequence 16'h0002, 16'h0003, 16'h0004, 16'h8421 → 32'h00000033, 32'h0000003C, 32'h00000055, 32'hFF55330F, in order.
3. m_ready=0, push 5 words with FIFO_DEPTH=4:
   - s_ready drops after the 4th accept; fifo_level=4; 5th word held by source.
   - Then m_ready=1: all 5 words delivered in order, and s_ready stays 0 on the cycle the FIFO is full even while popping.
4. With the FIFO at level 2, assert s_valid and m_ready together for 10 cycles → level stays 2; word count delivered = pushed; no duplicates or drops.
5. With level=3, pulse clear with s_valid=1 → level=0, m_valid=0, words_encoded=0; the word presented in the clear cycle is not accepted.
6. (RM13_ENCODER_ERR_INJECT_EN) lane mask 4'b0001:
   - data 1 bit 3 → 0x07; data 2 bit 7 → 0xB3; data 3 bit 6 → 0x7C; data 4 bit 5 → 0x75; inj_count=4.
   - Feeding these through decoder_top returns 1, 2, 3, 4.
